// File: rtl/serial_bus_arbiter.sv
// Two-master serial bus arbiter: round-robin on ties, grant held until done/abort/watchdog,
// followed by one dead turnaround cycle before the next arbitration.
module serial_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       bus_done,
    output logic [1:0] grant,
    output logic       grant_owner,
    output logic       bus_busy,
    output logic       timeout_err
);

    localparam logic [CNT_WIDTH-1:0] WdogLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] wdog_q, wdog_d;
    logic                 last_q, last_d;
    logic                 sel;
    logic                 owner_req;

    assign owner_req = req[owner_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        wdog_d    = wdog_q;
        last_d    = last_q;
        sel       = 1'b0;

        case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    // On a tie the master that did not own the bus last goes first.
                    sel     = (req == 2'b11) ? ~last_q : req[1];
                    grant_d = sel ? 2'b10 : 2'b01;
                    owner_d = sel;
                    busy_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (bus_done || !owner_req || (wdog_q == WdogLast)) begin
                    // Only a pure watchdog expiry flags an error; done and abort win over it.
                    timeout_d = !bus_done && owner_req;
                    grant_d   = 2'b00;
                    busy_d    = 1'b0;
                    last_d    = owner_q;
                    state_d   = StRelease;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
            last_q    <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_owner = owner_q;
    assign bus_busy    = busy_q;
    assign timeout_err = timeout_q;

endmodule
